// File: rtl/sw_debounce_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg -- shared definitions for the switch debouncer slice.
//
// Contents:
//   SW_WIDTH_DEFAULT   default number of switch bits conditioned
//   SW_DB_CNT_DEFAULT  default debounce length in clock cycles (legal 2..65535)
//   hold_state_e       state of the single-entry event holding register
//   cnt_width()        width of a per-bit debounce counter for a given DB_CNT
// -----------------------------------------------------------------------------
package sw_pkg;

  localparam int unsigned SW_WIDTH_DEFAULT  = 16;
  localparam int unsigned SW_DB_CNT_DEFAULT = 20000;

  // The holding register has one slot: it either has an event for the
  // consumer or it does not.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_e;

  // The counter runs 0..DB_CNT-1, so clog2(DB_CNT) bits always suffice.
  // DB_CNT >= 2 keeps the result at least one bit wide.
  function automatic int unsigned cnt_width(input int unsigned db_cnt);
    return $clog2(db_cnt);
  endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// -----------------------------------------------------------------------------
// sw_debounce_if -- change-event channel from the debouncer to its consumer.
//
// Signals:
//   evt_valid  producer -> consumer  event pending (holding register FULL)
//   evt_ready  consumer -> producer  event accepted when valid & ready at an edge
//   evt_mask   producer -> consumer  sw_o bits that changed since last accept
//   evt_value  producer -> consumer  sw_o value captured with the event
//   evt_ovf    producer -> consumer  sticky: at least one event was coalesced
//
// Modports: master = debouncer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface sw_debounce_if #(
  parameter int unsigned WIDTH = 16
);

  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_mask;
  logic [WIDTH-1:0] evt_value;
  logic             evt_ovf;

  modport master (
    output evt_valid,
    output evt_mask,
    output evt_value,
    output evt_ovf,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_mask,
    input  evt_value,
    input  evt_ovf,
    output evt_ready
  );

endinterface

// File: rtl/sw_debounce_db_bit.sv
// -----------------------------------------------------------------------------
// sw_db_bit -- one switch bit: optional two-flop synchronizer followed by a
// debounce counter that owns the stable output bit.
//
// Ports:
//   clk     clock, all state on the rising edge
//   rstn    synchronous reset, ACTIVE HIGH (name kept for codebase consistency)
//   din     raw asynchronous switch bit
//   dout    debounced stable bit
//   toggle  high in the cycle whose closing edge flips dout (feeds the event
//           logic in the parent so it sees the change on the same edge)
//
// Parameters:
//   DB_CNT  consecutive differing cycles needed to accept a new level (2..65535)
//
// Configuration macro: SW_DEBOUNCE_SYNC_EN
//   defined   -> two-flop synchronizer in front of the counter (+2 cycles)
//   undefined -> din feeds the counter directly (simulation use only)
// -----------------------------------------------------------------------------
module sw_db_bit
  import sw_pkg::*;
#(
  parameter int unsigned DB_CNT = SW_DB_CNT_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout,
  output logic toggle
);

  localparam int unsigned           CNT_W    = cnt_width(DB_CNT);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DB_CNT - 1);

  logic             din_s;
  logic [CNT_W-1:0] cnt_q;
  logic             dout_q;
  logic             diff;

`ifdef SW_DEBOUNCE_SYNC_EN
  // Two-flop synchronizer: the switch is asynchronous to clk, so the first
  // flop may go metastable; only the second flop's output is used.
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rstn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], din};
    end
  end

  assign din_s = sync_q[1];
`else
  assign din_s = din;
`endif

  assign diff   = din_s ^ dout_q;
  // The count reaching DB_CNT-1 while still differing means this is the
  // DB_CNT-th consecutive differing sample: flip on this edge.
  assign toggle = diff & (cnt_q == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, matching real hardware.
  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else if (!diff) begin
      // Any sample equal to the stable level restarts the count, which is
      // what rejects glitches shorter than DB_CNT cycles.
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q  <= '0;
      dout_q <= ~dout_q;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce -- WIDTH independent switch debouncers plus a single-entry
// change-event holding register with coalescing.
//
// Ports:
//   clk      clock, all state on the rising edge
//   rstn     synchronous reset, ACTIVE HIGH (name kept for codebase consistency)
//   sw_i     raw asynchronous board switches
//   sw_o     debounced stable switch vector
//   evt      sw_debounce_if.master: evt_valid/evt_ready handshake with
//            evt_mask, evt_value and sticky evt_ovf
//
// Parameters:
//   WIDTH    number of switch bits (default 16)
//   DB_CNT   debounce length in cycles, legal range 2..65535 (default 20000)
//
// Configuration macro: SW_DEBOUNCE_SYNC_EN (see sw_db_bit). With it defined a
// clean change reaches sw_o DB_CNT+2 cycles after the first sampling edge;
// without it, DB_CNT cycles.
//
// Event behaviour: whenever sw_o changes, an event (mask = changed bits,
// value = new sw_o) is offered. If the previous event has not been accepted
// yet, the new one is merged into it (masks OR-ed, value replaced) and
// evt_ovf is set; evt_ovf only clears on reset.
// -----------------------------------------------------------------------------
module sw_debounce
  import sw_pkg::*;
#(
  parameter int unsigned WIDTH  = SW_WIDTH_DEFAULT,
  parameter int unsigned DB_CNT = SW_DB_CNT_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] sw_o,
  sw_debounce_if.master    evt
);

  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] new_mask;
  logic [WIDTH-1:0] new_value;
  logic             new_evt;

  hold_state_e      state_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] value_q;
  logic             ovf_q;

  // ---------------------------------------------------------------------------
  // Per-bit debouncers
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_db_bit #(
      .DB_CNT (DB_CNT)
    ) u_db_bit (
      .clk    (clk),
      .rstn   (rstn),
      .din    (sw_i[i]),
      .dout   (sw_o[i]),
      .toggle (toggle[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Change detection: the toggle strobes describe the edge on which sw_o will
  // change, so the event is captured on that same edge and evt_valid rises
  // together with the new sw_o.
  // ---------------------------------------------------------------------------
  assign new_mask  = toggle;
  assign new_value = sw_o ^ toggle;
  assign new_evt   = |toggle;

  // ---------------------------------------------------------------------------
  // Holding register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= EMPTY;
      mask_q  <= '0;
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (new_evt) begin
            state_q <= FULL;
            mask_q  <= new_mask;
            value_q <= new_value;
          end
        end
        FULL: begin
          if (evt.evt_ready) begin
            // The old event leaves this edge; a simultaneous new one takes
            // its place untouched, so nothing is lost and no overflow occurs.
            if (new_evt) begin
              mask_q  <= new_mask;
              value_q <= new_value;
            end else begin
              state_q <= EMPTY;
            end
          end else if (new_evt) begin
            // Consumer is stalled: merge so no changed bit is forgotten.
            mask_q  <= mask_q | new_mask;
            value_q <= new_value;
            ovf_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign evt.evt_valid = (state_q == FULL);
  assign evt.evt_mask  = mask_q;
  assign evt.evt_value = value_q;
  assign evt.evt_ovf   = ovf_q;

endmodule
